// File: rtl/nonce_scheduler_if.sv
// Work-intake and golden-nonce channels of the nonce scheduler.
interface nonce_scheduler_if;
    // Both channels: a beat transfers on a rising edge where valid && ready are
    // both high; the sender holds its payload stable while valid is high.
    logic         work_valid;
    logic         work_ready;
    logic [255:0] work_midstate;
    logic [95:0]  work_data;
    logic         gn_valid;
    logic         gn_ready;
    logic [31:0]  gn_nonce;

    modport master (
        output work_valid, work_midstate, work_data, gn_ready,
        input  work_ready, gn_valid, gn_nonce
    );

    modport slave (
        input  work_valid, work_midstate, work_data, gn_ready,
        output work_ready, gn_valid, gn_nonce
    );
endinterface

// File: rtl/nonce_scheduler.sv
// Walks the 32-bit nonce space for an unrolled SHA-256 pair, drives the hasher
// inputs and queues golden nonces, compensating the hasher pipeline latency.
module nonce_scheduler #(
    parameter int unsigned LOOP_LOG2   = 5,
    parameter int unsigned FIFO_DEPTH  = 4,
    // Nonce loaded on work accept; nonzero only to shorten simulations.
    parameter logic [31:0] NONCE_START = 32'h0000_0000
) (
    input  logic                    hash_clk,
    input  logic                    reset,
    nonce_scheduler_if.slave        bus,
    output logic [5:0]              cnt,
    output logic                    feedback,
    output logic [255:0]            state,
    output logic [511:0]            data,
    input  logic [31:0]             hash_top,
    output logic                    running,
    output logic                    exhausted,
    output logic                    overflow,
    output logic [1:0]              fsm_state
);

    localparam int unsigned LOOP   = 1 << LOOP_LOG2;
    localparam int unsigned OFFSET = (LOOP_LOG2 == 0) ? 131 :
                                     (LOOP_LOG2 == 1) ? 66  :
                                     (1 << (7 - LOOP_LOG2)) + 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W  = PTR_W + 1;

    localparam logic [7:0]       OFFSET_M = 8'(OFFSET);
    localparam logic [31:0]      OFFSET_N = 32'(OFFSET);
    localparam logic [5:0]       CNT_MASK = 6'(LOOP - 1);
    localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fsm_e;

    fsm_e             fsm_q, fsm_d;
    logic [5:0]       cnt_q, cnt_d, cnt_step;
    logic             feedback_q, feedback_d, fb_step, nonce_inc;
    logic [31:0]      nonce_q, nonce_d;
    logic [7:0]       mask_q, mask_d;
    logic [7:0]       drain_q, drain_d;
    logic             tail_q, tail_d;
    logic [255:0]     midstate_q, midstate_d;
    logic [95:0]      wdata_q, wdata_d;
    logic [255:0]     state_q, state_d;
    logic [511:0]     data_q, data_d;
    logic             fb_dly_q;
    logic             golden_q, golden_d;
    logic             exhausted_q, exhausted_d;
    logic             overflow_q, overflow_d;

    logic             accept, push, pop, full, wr_en, drop;
    logic [31:0]      fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    assign accept    = bus.work_valid;
    assign cnt_step  = (LOOP == 1) ? 6'd0 : ((cnt_q + 6'd1) & CNT_MASK);
    assign fb_step   = (LOOP != 1) && (cnt_step != 6'd0);
    assign nonce_inc = !fb_step;

    always_comb begin
        fsm_d       = fsm_q;
        cnt_d       = cnt_q;
        feedback_d  = feedback_q;
        nonce_d     = nonce_q;
        mask_d      = mask_q;
        drain_d     = drain_q;
        tail_d      = tail_q;
        midstate_d  = midstate_q;
        wdata_d     = wdata_q;
        exhausted_d = 1'b0;

        if (accept) begin
            midstate_d = bus.work_midstate;
            wdata_d    = bus.work_data;
            nonce_d    = NONCE_START;
            cnt_d      = 6'd0;
            feedback_d = 1'b0;
            mask_d     = OFFSET_M;
            drain_d    = OFFSET_M;
            tail_d     = 1'b0;
            fsm_d      = ST_RUN;
        end else begin
            case (fsm_q)
                ST_RUN, ST_DRAIN: begin
                    cnt_d      = cnt_step;
                    feedback_d = fb_step;
                    if (nonce_inc) begin
                        nonce_d = nonce_q + 32'd1;
                        if (mask_q != 8'd0) mask_d = mask_q - 8'd1;
                    end
                    if (fsm_q == ST_RUN) begin
                        if (nonce_inc && (nonce_q == 32'hFFFF_FFFF)) begin
                            fsm_d   = ST_DRAIN;
                            drain_d = OFFSET_M;
                            tail_d  = 1'b0;
                        end
                    end else if (drain_q != 8'd0) begin
                        if (nonce_inc) drain_d = drain_q - 8'd1;
                    end else if (!tail_q) begin
                        tail_d = 1'b1;
                    end else begin
                        // Two tail cycles let the last in-flight flags land first.
                        fsm_d       = ST_IDLE;
                        cnt_d       = 6'd0;
                        feedback_d  = 1'b0;
                        exhausted_d = 1'b1;
                    end
                end
                default: begin
                    fsm_d      = ST_IDLE;
                    cnt_d      = 6'd0;
                    feedback_d = 1'b0;
                end
            endcase
        end
    end

    assign state_d  = midstate_d;
    assign data_d   = {32'h0000_0280, 320'h0, 32'h8000_0000, nonce_d, wdata_d};
    assign golden_d = (hash_top == 32'd0) && !fb_dly_q;

    // Results are tagged with the nonce OFFSET steps back; the mask hides
    // results still belonging to the previous work unit.
    assign push  = golden_q && (mask_q == 8'd0) && (fsm_q != ST_IDLE) && !accept;
    assign pop   = (occ_q != '0) && bus.gn_ready;
    assign full  = (occ_q == DEPTH_C);
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    assign wr_ptr_d   = wr_en ? PTR_W'(wr_ptr_q + 1'b1) : wr_ptr_q;
    assign rd_ptr_d   = pop   ? PTR_W'(rd_ptr_q + 1'b1) : rd_ptr_q;
    assign occ_d      = occ_q + OCC_W'(wr_en) - OCC_W'(pop);
    assign overflow_d = accept ? 1'b0 : (overflow_q | drop);

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            fsm_q       <= ST_IDLE;
            cnt_q       <= 6'd0;
            feedback_q  <= 1'b0;
            nonce_q     <= 32'd0;
            mask_q      <= OFFSET_M;
            drain_q     <= OFFSET_M;
            tail_q      <= 1'b0;
            midstate_q  <= '0;
            wdata_q     <= '0;
            state_q     <= '0;
            data_q      <= '0;
            fb_dly_q    <= 1'b0;
            golden_q    <= 1'b0;
            exhausted_q <= 1'b0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
        end else begin
            fsm_q       <= fsm_d;
            cnt_q       <= cnt_d;
            feedback_q  <= feedback_d;
            nonce_q     <= nonce_d;
            mask_q      <= mask_d;
            drain_q     <= drain_d;
            tail_q      <= tail_d;
            midstate_q  <= midstate_d;
            wdata_q     <= wdata_d;
            state_q     <= state_d;
            data_q      <= data_d;
            fb_dly_q    <= feedback_q;
            golden_q    <= golden_d;
            exhausted_q <= exhausted_d;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
        end
    end

    always_ff @(posedge hash_clk) begin
        if (wr_en) fifo_mem_q[wr_ptr_q] <= nonce_q - OFFSET_N;
    end

    assign bus.work_ready = 1'b1;
    assign bus.gn_valid   = (occ_q != '0);
    assign bus.gn_nonce   = fifo_mem_q[rd_ptr_q];

    assign cnt       = cnt_q;
    assign feedback  = feedback_q;
    assign state     = state_q;
    assign data      = data_q;
    assign running   = (fsm_q != ST_IDLE);
    assign exhausted = exhausted_q;
    assign overflow  = overflow_q;
    assign fsm_state = fsm_q;

endmodule

// File: tb/tb_nonce_scheduler.sv
// Bench for nonce_scheduler: vector table of golden injections, random run
// against a timeline model, and hand sequences for overflow, reset and wrap.
module tb_nonce_scheduler;

    localparam int unsigned LOOP_LOG2 = 5;
    localparam int unsigned LOOP      = 1 << LOOP_LOG2;
    localparam int unsigned OFFSET    = 5;
    localparam int unsigned DEPTH     = 4;
    localparam logic [31:0] START_A   = 32'h0000_1000;
    localparam logic [31:0] START_B   = 32'hFFFF_FFF0;
    localparam int          WRAP_K    = 16 * LOOP;
    localparam int          EXH_K     = WRAP_K + OFFSET * LOOP + 2;
    localparam logic [31:0] HT_IDLE   = 32'hDEAD_BEEF;

    logic hash_clk = 1'b0;
    logic reset;
    always #5 hash_clk = ~hash_clk;

    nonce_scheduler_if bus_a ();
    nonce_scheduler_if bus_b ();

    logic [5:0]   cnt_a, cnt_b;
    logic         fb_a, fb_b, running_a, running_b, exh_a, exh_b, ovf_a, ovf_b;
    logic [255:0] state_a, state_b;
    logic [511:0] data_a, data_b;
    logic [31:0]  hash_top_a, hash_top_b;
    logic [1:0]   fsm_a, fsm_b;

    nonce_scheduler #(.LOOP_LOG2(LOOP_LOG2), .FIFO_DEPTH(DEPTH), .NONCE_START(START_A)) dut_a (
        .hash_clk(hash_clk), .reset(reset), .bus(bus_a), .cnt(cnt_a), .feedback(fb_a),
        .state(state_a), .data(data_a), .hash_top(hash_top_a), .running(running_a),
        .exhausted(exh_a), .overflow(ovf_a), .fsm_state(fsm_a)
    );

    nonce_scheduler #(.LOOP_LOG2(LOOP_LOG2), .FIFO_DEPTH(DEPTH), .NONCE_START(START_B)) dut_b (
        .hash_clk(hash_clk), .reset(reset), .bus(bus_b), .cnt(cnt_b), .feedback(fb_b),
        .state(state_b), .data(data_b), .hash_top(hash_top_b), .running(running_b),
        .exhausted(exh_b), .overflow(ovf_b), .fsm_state(fsm_b)
    );

    typedef struct {
        int unsigned step;
        int unsigned phase;
        logic        exp_valid;
        logic [31:0] exp_nonce;
    } golden_vec_t;

    golden_vec_t  gv [8];
    int unsigned  n_checks = 0;
    int unsigned  n_pass   = 0;
    int           k_now    = 0;
    logic [255:0] ms_exp;
    logic [95:0]  wd_exp;
    logic [31:0]  exp_q [$];
    logic         m_ovf, pend_valid, do_push, hz, rdy;
    logic [31:0]  pend_val, push_val;
    int           pulses, pulse_k;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (k=%0d)", name, act, exp, k_now);
    endtask

    task automatic tick();
        @(negedge hash_clk);
        k_now++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic accept(input bit to_b);
        ms_exp = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        wd_exp = {$urandom, $urandom, $urandom};
        if (to_b) begin
            bus_b.work_valid = 1'b1; bus_b.work_midstate = ms_exp; bus_b.work_data = wd_exp;
        end else begin
            bus_a.work_valid = 1'b1; bus_a.work_midstate = ms_exp; bus_a.work_data = wd_exp;
        end
        @(negedge hash_clk);
        bus_a.work_valid = 1'b0;
        bus_b.work_valid = 1'b0;
        k_now = 0;
    endtask

    task automatic goto_k(input int target);
        while (k_now < target) tick();
    endtask

    task automatic inject(input int k);
        goto_k(k);
        hash_top_a = 32'd0;
        tick();
        hash_top_a = HT_IDLE;
    endtask

    initial begin
        // step, phase within the 32-cycle round, expected push
        gv[0] = '{step: 0, phase: 1, exp_valid: 1'b0, exp_nonce: 32'h0};
        gv[1] = '{step: 3, phase: 1, exp_valid: 1'b0, exp_nonce: 32'h0};
        gv[2] = '{step: 4, phase: 1, exp_valid: 1'b0, exp_nonce: 32'h0};
        gv[3] = '{step: 5, phase: 1, exp_valid: 1'b1, exp_nonce: 32'h0000_1000};
        gv[4] = '{step: 9, phase: 1, exp_valid: 1'b1, exp_nonce: 32'h0000_1004};
        gv[5] = '{step: 6, phase: 5, exp_valid: 1'b0, exp_nonce: 32'h0};
        gv[6] = '{step: 7, phase: 0, exp_valid: 1'b0, exp_nonce: 32'h0};
        gv[7] = '{step: 7, phase: 2, exp_valid: 1'b0, exp_nonce: 32'h0};

        reset = 1'b1;
        hash_top_a = HT_IDLE;
        hash_top_b = HT_IDLE;
        bus_a.work_valid = 1'b1; bus_a.work_midstate = '1; bus_a.work_data = '1; bus_a.gn_ready = 1'b0;
        bus_b.work_valid = 1'b0; bus_b.work_midstate = '0; bus_b.work_data = '0; bus_b.gn_ready = 1'b0;
        tick();
        tick();

        // Reset state, with a work offer held against reset
        check("rst_running", running_a, 1'b0);
        check("rst_cnt", cnt_a, 6'd0);
        check("rst_feedback", fb_a, 1'b0);
        check("rst_gn_valid", bus_a.gn_valid, 1'b0);
        check("rst_overflow", ovf_a, 1'b0);
        check("rst_exhausted", exh_a, 1'b0);
        check("rst_state", state_a, 256'd0);
        check("rst_data_any", |data_a, 1'b0);
        check("rst_work_ready", bus_a.work_ready, 1'b1);
        check("rst_b_running", running_b, 1'b0);
        reset = 1'b0;
        bus_a.work_valid = 1'b0;
        tick();
        check("idle_running", running_a, 1'b0);
        check("idle_cnt", cnt_a, 6'd0);
        check("idle_nonce", data_a[127:96], 32'd0);

        // Golden injection vectors
        for (int i = 0; i < 8; i++) begin
            do_reset();
            accept(1'b0);
            inject(int'(LOOP * gv[i].step + gv[i].phase));
            goto_k(int'(LOOP * gv[i].step + gv[i].phase + 2));
            check("vec_gn_valid", bus_a.gn_valid, gv[i].exp_valid);
            if (gv[i].exp_valid) check("vec_gn_nonce", bus_a.gn_nonce, gv[i].exp_nonce);
            check("vec_overflow", ovf_a, 1'b0);
        end

        // Random run against a timeline model
        do_reset();
        accept(1'b0);
        exp_q.delete();
        m_ovf = 1'b0;
        pend_valid = 1'b0;
        pend_val = 32'd0;
        check("rand_state_latched", state_a, ms_exp);
        check("rand_data_lo", data_a[95:0], wd_exp);
        check("rand_data_hdr_hi", data_a[511:480], 32'h0000_0280);
        check("rand_data_hdr_pad", data_a[159:128], 32'h8000_0000);
        for (int c = 0; c < int'(LOOP) * 20; c++) begin
            check("rand_cnt", cnt_a, 6'(k_now % LOOP));
            check("rand_feedback", fb_a, (k_now % LOOP) != 0);
            check("rand_nonce", data_a[127:96], START_A + 32'(k_now / LOOP));
            check("rand_running", running_a, 1'b1);
            check("rand_gn_valid", bus_a.gn_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) check("rand_gn_nonce", bus_a.gn_nonce, exp_q[0]);
            check("rand_overflow", ovf_a, m_ovf);

            hz  = ($urandom_range(0, 3) != 0);
            rdy = (c < int'(LOOP) * 12) ? ($urandom_range(0, 63) == 0) : ($urandom_range(0, 3) == 0);
            hash_top_a = hz ? 32'd0 : 32'($urandom_range(1, 32'hFFFF_FFFF));
            bus_a.gn_ready = rdy;

            do_push    = pend_valid;
            push_val   = pend_val;
            pend_valid = hz && (k_now % LOOP == 1) && (k_now / LOOP >= OFFSET);
            pend_val   = START_A + 32'(k_now / LOOP) - 32'(OFFSET);
            if (rdy && exp_q.size() != 0) void'(exp_q.pop_front());
            if (do_push) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(push_val);
                else m_ovf = 1'b1;
            end
            tick();
        end
        bus_a.gn_ready = 1'b0;
        hash_top_a = HT_IDLE;

        // Overflow, then abort with new work keeping the queue, then drain
        do_reset();
        accept(1'b0);
        for (int s = 5; s <= 9; s++) inject(s * int'(LOOP) + 1);
        goto_k(9 * int'(LOOP) + 3);
        check("ovf_flag", ovf_a, 1'b1);
        check("ovf_head", bus_a.gn_nonce, 32'h0000_1000);
        accept(1'b0);
        check("abort_ovf_clear", ovf_a, 1'b0);
        check("abort_running", running_a, 1'b1);
        check("abort_no_exhaust", exh_a, 1'b0);
        check("abort_cnt", cnt_a, 6'd0);
        bus_a.gn_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", bus_a.gn_valid, 1'b1);
            check("drain_nonce", bus_a.gn_nonce, START_A + 32'(i));
            tick();
        end
        check("drain_empty", bus_a.gn_valid, 1'b0);
        bus_a.gn_ready = 1'b0;

        // Reset mid-run with two entries queued
        do_reset();
        accept(1'b0);
        inject(5 * int'(LOOP) + 1);
        inject(6 * int'(LOOP) + 1);
        goto_k(6 * int'(LOOP) + 3);
        check("pre_rst_valid", bus_a.gn_valid, 1'b1);
        check("pre_rst_head", bus_a.gn_nonce, START_A);
        reset = 1'b1;
        tick();
        check("midrst_gn_valid", bus_a.gn_valid, 1'b0);
        check("midrst_cnt", cnt_a, 6'd0);
        check("midrst_running", running_a, 1'b0);
        check("midrst_overflow", ovf_a, 1'b0);
        reset = 1'b0;
        tick();
        check("post_rst_gn_valid", bus_a.gn_valid, 1'b0);

        // Nonce-space wrap, drain and exhaustion on the preloaded instance
        do_reset();
        accept(1'b1);
        pulses = 0;
        pulse_k = -1;
        for (int c = 0; c < EXH_K + 20; c++) begin
            if (exh_b) begin
                pulses++;
                pulse_k = k_now;
            end
            if (k_now == WRAP_K - 1) check("prewrap_nonce", data_b[127:96], 32'hFFFF_FFFF);
            if (k_now == WRAP_K) begin
                check("wrap_nonce", data_b[127:96], 32'd0);
                check("wrap_drain", fsm_b, 2'd2);
                check("wrap_running", running_b, 1'b1);
            end
            if (k_now == EXH_K - 1) check("pre_exh_running", running_b, 1'b1);
            if (k_now == EXH_K) begin
                check("exh_running", running_b, 1'b0);
                check("exh_feedback", fb_b, 1'b0);
                check("exh_cnt", cnt_b, 6'd0);
            end
            tick();
        end
        check("exh_pulses", 32'(pulses), 32'd1);
        check("exh_when", 32'(pulse_k), 32'(EXH_K));
        check("idle_hold_nonce", data_b[127:96], 32'(OFFSET));
        check("idle_b_feedback", fb_b, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/nonce_scheduler.md
NONCE_SCHEDULER -- requirements
Module: nonce_scheduler

Interface
REQ-001 Parameter LOOP_LOG2, default 5: hasher unroll setting, legal 0..5; LOOP = 1<<LOOP_LOG2.
REQ-002 Parameter FIFO_DEPTH, default 4: golden-nonce queue entries, power of two, 2..16.
REQ-003 Derived OFFSET: 131 if LOOP_LOG2==0, 66 if LOOP_LOG2==1, else (1<<(7-LOOP_LOG2))+1.
REQ-004 hash_clk  in  1  sole clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 work_valid  in  1  new work offered.
REQ-007 work_ready  out  1  new work accepted when work_valid&work_ready.
REQ-008 work_midstate  in  256  midstate for the new work.
REQ-009 work_data  in  96  last 96 header bits, excluding the nonce.
REQ-010 cnt  out  6  round counter to both hashers.
REQ-011 feedback  out  1  hasher feedback select.
REQ-012 state  out  256  midstate to the first hasher.
REQ-013 data  out  512  message block to the first hasher.
REQ-014 hash_top  in  32  bits [255:224] of the second hasher output.
REQ-015 gn_valid  out  1  golden nonce available.
REQ-016 gn_ready  in  1  consumer takes gn_nonce when gn_valid&gn_ready.
REQ-017 gn_nonce  out  32  oldest queued golden nonce.
REQ-018 running  out  1  high in RUN or DRAIN.
REQ-019 exhausted  out  1  one-cycle pulse when a work unit's nonce space is fully checked.
REQ-020 overflow  out  1  sticky flag: a golden nonce was dropped.

Function
REQ-021 States are IDLE, RUN, and DRAIN; work_ready is 1 in all states.
REQ-022 On accept in any state: latch midstate and data, set nonce=0 and cnt=0, clear overflow, set a mask counter to OFFSET, and enter RUN the next cycle.
REQ-023 In RUN/DRAIN, cnt_next = (cnt+1)&(LOOP-1), or 0 when LOOP==1; feedback <= (LOOP!=1)&&(cnt_next!=0).
REQ-024 nonce increments by 1 (mod 2^32) on each cycle where feedback_next==0; otherwise it holds.
REQ-025 Each cycle: state <= latched midstate; data <= {32'h00000280, 320'h0, 32'h80000000, nonce_next, latched work_data}.
REQ-026 The golden flag is registered: (hash_top==0) && !feedback_d1, where feedback_d1 is feedback delayed by one cycle.
REQ-027 One cycle after the flag, push (nonce - OFFSET) mod 2^32, only if the mask counter is 0.
REQ-028 The mask counter decrements at each nonce increment, saturates at 0, and suppresses stale results from prior work.
REQ-029 RUN->DRAIN occurs when the nonce increments from 0xFFFFFFFF to 0; the nonce keeps wrapping through 0..OFFSET-1.
REQ-030 DRAIN->IDLE occurs after OFFSET further nonce increments, plus 2 cycles for flag alignment, with exhausted pulsed on the transition.
REQ-031 In IDLE: cnt=0, feedback=0, nonce holds, and no pushes occur (in-flight results are discarded).
REQ-032 Accepting work during RUN/DRAIN aborts the current unit immediately, with no exhausted pulse; already-queued nonces remain in the FIFO.
REQ-033 FIFO: gn_valid = !empty; gn_nonce = head entry; pop on gn_valid&gn_ready.
REQ-034 Push when full without a same-cycle pop drops the new nonce and sets overflow.
REQ-035 Push and pop in the same cycle on a full FIFO both succeed with no drop.
REQ-036 Push and pop in the same cycle on an empty FIFO: the push is stored and gn_valid rises next cycle (no bypass).
REQ-037 Occupancy counter width is log2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.

Reset
REQ-038 With reset high at a clock edge: state IDLE, cnt=0, feedback=0, nonce=0, mask=OFFSET, FIFO emptied, gn_valid=0, overflow=0, exhausted=0, running=0, state/data outputs=0.
REQ-039 Reset takes precedence over a simultaneous work accept, push, or pop; reset in mid-RUN discards all queued nonces.

Verification
REQ-040 LOOP_LOG2=5: accept work -> cnt cycles 0..31; feedback=0 only on cycles where cnt=0; nonce steps every 32 cycles; data[127:96] tracks nonce_next.
REQ-041 LOOP_LOG2=5 (OFFSET=5), hash_top=0 forced on the feedback_d1=0 cycle at internal nonce 0x00001009 -> gn_nonce=0x00001004 and gn_valid asserted.
REQ-042 The same hash_top=0 forcing within the first 5 nonce steps after accept -> no push, gn_valid stays 0.
REQ-043 FIFO_DEPTH=4, gn_ready=0, 5 golden events -> 4 queued in order, overflow=1; then gn_ready=1 -> 4 pops, then gn_valid=0.
REQ-044 LOOP_LOG2=5, preload nonce 0xFFFFFFF0 in sim -> DRAIN at wrap, exhausted pulses once after 5 more steps + 2 cycles, then IDLE with feedback=0.
REQ-045 Reset asserted mid-RUN with 2 entries queued -> next cycle gn_valid=0, cnt=0, running=0, overflow=0.
